// File: rtl/audio_frame_pkg.sv
// rtl/audio_frame_pkg.sv - shared types and frame builder for the audio frame packer
// Purpose: frame geometry constants, FIFO entry layout, packer FSM states and
//          the 48-bit frame builder used when a stereo pair is loaded.
// Optional feature: AUDIO_CHECKSUM_EN puts the XOR checksum into frame[7:0];
//          without it that byte is zero and no XOR logic exists.
package audio_frame_pkg;

   localparam int FRAME_BITS       = 48;
   localparam int CHUNK_BITS       = 6;
   localparam int CHUNKS_PER_FRAME = 8;
   localparam int SEQ_BITS         = 4;
   localparam int SAMPLE_BITS      = 12;
   // Chunk index runs 0..CHUNKS_PER_FRAME; the terminal value means "frame fully sent".
   localparam int CHUNK_IDX_BITS   = $clog2(CHUNKS_PER_FRAME) + 1;

   typedef struct packed {
      logic [SEQ_BITS-1:0]    seq;
      logic [SAMPLE_BITS-1:0] left;
      logic [SAMPLE_BITS-1:0] right;
   } fifo_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SEND
   } state_t;

   // {sync, seq, left, right, 4'h0, checksum}, MSB first.
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0]  sync,
                                                         input fifo_entry_t e);
      logic [FRAME_BITS-1:0] f;
      f = {sync, e.seq, e.left, e.right, 4'h0, 8'h00};
`ifdef AUDIO_CHECKSUM_EN
      f[7:0] = f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8];
`endif
      return f;
   endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - small synchronous FIFO of stereo pair entries
// Purpose: buffers {seq, left, right} entries between the ADC capture and the
//          frame serialiser. A write while full is ignored (the caller flags it).
// Ports:
//   clk_40MHz, nReset  clock, asynchronous active-low reset (empties the FIFO)
//   wr_en_i, wr_data_i write request and entry; ignored when full_o
//   rd_en_i            pop request; ignored when empty_o
//   rd_data_o          head entry, valid while !empty_o
//   full_o, empty_o    status
//   level_o            entries currently stored
module audio_sample_fifo
   import audio_frame_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_40MHz,
   input  logic                     nReset,
   input  logic                     wr_en_i,
   input  fifo_entry_t              wr_data_i,
   input  logic                     rd_en_i,
   output fifo_entry_t              rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   fifo_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [LVL_W-1:0]   level_q;
   logic               do_wr;
   logic               do_rd;

   assign full_o    = (level_q == LVL_W'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign level_o   = level_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // Full is judged on the current level, so a same-cycle pop never rescues a write.
   assign do_wr = wr_en_i & ~full_o;
   assign do_rd = rd_en_i & ~empty_o;

   always_ff @(posedge clk_40MHz or negedge nReset) begin
      if (!nReset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset: pointers alone define what is valid.
   always_ff @(posedge clk_40MHz) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/audio_frame_packer.sv
// rtl/audio_frame_packer.sv - packs stereo audio pairs into 6-bit aux chunks of RF words
// Purpose: captures each stereo pair on audio_ready with a 4-bit sequence number,
//          buffers it, and emits a 48-bit frame as eight 6-bit chunks, one per
//          rf_strobe, alongside the RF sample words.
// Optional feature: define AUDIO_CHECKSUM_EN to carry the XOR checksum in frame[7:0].
// Ports:
//   clk_40MHz, nReset       clock, asynchronous active-low reset
//   audio_left/right        12-bit samples, valid with audio_ready
//   audio_ready             single-cycle new-pair pulse
//   rf_strobe               one cycle per RF word; advances the chunk
//   clear_overflow          synchronous clear of overflow
//   aux_out                 current chunk (0 when idle)
//   aux_frame, aux_start    chunk present / chunk 0 present
//   overflow                sticky pair-dropped flag
//   fifo_level              entries buffered in the FIFO
module audio_frame_packer
   import audio_frame_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic                          clk_40MHz,
   input  logic                          nReset,
   input  logic [SAMPLE_BITS-1:0]        audio_left,
   input  logic [SAMPLE_BITS-1:0]        audio_right,
   input  logic                          audio_ready,
   input  logic                          rf_strobe,
   input  logic                          clear_overflow,
   output logic [CHUNK_BITS-1:0]         aux_out,
   output logic                          aux_frame,
   output logic                          aux_start,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam logic [CHUNK_IDX_BITS-1:0] K_DONE = CHUNK_IDX_BITS'(CHUNKS_PER_FRAME);

   state_t                     state_q, state_d;
   logic [CHUNK_IDX_BITS-1:0]  k_q, k_d;
   logic [FRAME_BITS-1:0]      frame_q, frame_d;
   fifo_entry_t                entry_q, entry_d;
   logic                       next_rdy_q, next_rdy_d;
   logic [CHUNK_BITS-1:0]      aux_out_q, aux_out_d;
   logic                       aux_frame_q, aux_frame_d;
   logic                       aux_start_q, aux_start_d;
   logic [SEQ_BITS-1:0]        seq_q;
   logic                       overflow_q;

   fifo_entry_t                wr_entry;
   fifo_entry_t                rd_entry;
   logic                       fifo_rd;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       fifo_drop;

   assign wr_entry.seq   = seq_q;
   assign wr_entry.left  = audio_left;
   assign wr_entry.right = audio_right;
   assign fifo_drop      = audio_ready & fifo_full;

   audio_sample_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_40MHz (clk_40MHz),
      .nReset    (nReset),
      .wr_en_i   (audio_ready),
      .wr_data_i (wr_entry),
      .rd_en_i   (fifo_rd),
      .rd_data_o (rd_entry),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (fifo_level)
   );

   // Sequence advances on every pair, dropped or not, so the receiver sees gaps.
   always_ff @(posedge clk_40MHz or negedge nReset) begin
      if (!nReset) begin
         seq_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (audio_ready) seq_q <= seq_q + 1'b1;
         if (fifo_drop)           overflow_q <= 1'b1;
         else if (clear_overflow) overflow_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_40MHz or negedge nReset) begin
      if (!nReset) begin
         state_q     <= IDLE;
         k_q         <= '0;
         frame_q     <= '0;
         entry_q     <= '0;
         next_rdy_q  <= 1'b0;
         aux_out_q   <= '0;
         aux_frame_q <= 1'b0;
         aux_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         frame_q     <= frame_d;
         entry_q     <= entry_d;
         next_rdy_q  <= next_rdy_d;
         aux_out_q   <= aux_out_d;
         aux_frame_q <= aux_frame_d;
         aux_start_q <= aux_start_d;
      end
   end

   // frame_q is a shift register: the head chunk always sits in the top CHUNK_BITS.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      frame_d     = frame_q;
      entry_d     = entry_q;
      next_rdy_d  = next_rdy_q;
      aux_out_d   = aux_out_q;
      aux_frame_d = aux_frame_q;
      aux_start_d = aux_start_q;
      fifo_rd     = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_rd = 1'b1;
               entry_d = rd_entry;
               state_d = LOAD;
            end
         end

         LOAD: begin
            frame_d    = build_frame(SYNC_BYTE, entry_q);
            k_d        = '0;
            next_rdy_d = 1'b0;
            state_d    = SEND;
         end

         SEND: begin
            if (k_q == K_DONE) begin
               if (rf_strobe) begin
                  if (next_rdy_q) begin
                     aux_out_d   = frame_q[FRAME_BITS-1 -: CHUNK_BITS];
                     frame_d     = {frame_q[FRAME_BITS-CHUNK_BITS-1:0], {CHUNK_BITS{1'b0}}};
                     aux_frame_d = 1'b1;
                     aux_start_d = 1'b1;
                     k_d         = CHUNK_IDX_BITS'(1);
                     next_rdy_d  = 1'b0;
                  end else begin
                     aux_out_d   = '0;
                     aux_frame_d = 1'b0;
                     aux_start_d = 1'b0;
                     state_d     = IDLE;
                  end
               end else if (!next_rdy_q && !fifo_empty) begin
                  // Chunk 7 is held in aux_out_q, so frame_q is free: pop and build
                  // the next frame in one go to keep back-to-back frames gapless.
                  fifo_rd    = 1'b1;
                  frame_d    = build_frame(SYNC_BYTE, rd_entry);
                  next_rdy_d = 1'b1;
               end
            end else if (rf_strobe) begin
               aux_out_d   = frame_q[FRAME_BITS-1 -: CHUNK_BITS];
               frame_d     = {frame_q[FRAME_BITS-CHUNK_BITS-1:0], {CHUNK_BITS{1'b0}}};
               aux_frame_d = 1'b1;
               aux_start_d = (k_q == '0);
               k_d         = k_q + 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign aux_out   = aux_out_q;
   assign aux_frame = aux_frame_q;
   assign aux_start = aux_start_q;
   assign overflow  = overflow_q;

endmodule
